// File: rtl/wb_ddr2_port_arbiter.sv
// Round-robin Wishbone B3 arbiter folding NUM_MASTERS masters onto one DDR2 controller port.
// The grant is held for a whole bus cycle; an optional watchdog ends stalled transfers with err.
module wb_ddr2_port_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst,
  input  logic [NUM_MASTERS*AW-1:0]   wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]   wbm_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS*3-1:0]    wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]    wbm_bte_i,
  input  logic [NUM_MASTERS-1:0]      wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]      wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]      wbm_we_i,
  output logic [NUM_MASTERS-1:0]      wbm_ack_o,
  output logic [NUM_MASTERS-1:0]      wbm_err_o,
  output logic [NUM_MASTERS-1:0]      wbm_rty_o,
  output logic [DW-1:0]               wbm_dat_o,
  output logic [AW-1:0]               wbs_adr_o,
  output logic [DW-1:0]               wbs_dat_o,
  output logic [DW/8-1:0]             wbs_sel_o,
  output logic [2:0]                  wbs_cti_o,
  output logic [1:0]                  wbs_bte_o,
  output logic                        wbs_cyc_o,
  output logic                        wbs_stb_o,
  output logic                        wbs_we_o,
  input  logic                        wbs_ack_i,
  input  logic                        wbs_err_i,
  input  logic                        wbs_rty_i,
  input  logic [DW-1:0]               wbs_dat_i,
  output logic [NUM_MASTERS-1:0]      grant_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(NUM_MASTERS);
  localparam int unsigned WW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAbort} state_e;

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]          wd_cnt_q, wd_cnt_d;

  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_dat;
  logic [SW-1:0] m_sel;
  logic [2:0]    m_cti;
  logic [1:0]    m_bte;
  logic          m_cyc, m_stb, m_we;
  logic          found;
  logic [PW-1:0] winner;
  logic          busy, term, wd_fire;

  // Grant register is one-hot, so OR-ing the selected slices is a plain mux.
  always_comb begin
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    m_cti = '0;
    m_bte = '0;
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q[i]) begin
        m_adr = m_adr | wbm_adr_i[i*AW +: AW];
        m_dat = m_dat | wbm_dat_i[i*DW +: DW];
        m_sel = m_sel | wbm_sel_i[i*SW +: SW];
        m_cti = m_cti | wbm_cti_i[i*3 +: 3];
        m_bte = m_bte | wbm_bte_i[i*2 +: 2];
        m_cyc = m_cyc | wbm_cyc_i[i];
        m_stb = m_stb | wbm_stb_i[i];
        m_we  = m_we  | wbm_we_i[i];
      end
    end
  end

  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      int unsigned idx;
      idx = (32'(rr_ptr_q) + i) % NUM_MASTERS;
      if (!found && wbm_cyc_i[idx]) begin
        found  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

  assign busy = (state_q == StBusy);
  assign term = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // A real termination in the limit cycle wins over the watchdog.
  assign wd_fire = (TIMEOUT != 0) && busy && m_cyc && m_stb && !term &&
                   (wd_cnt_q == WW'(TIMEOUT - 1));

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d  = NUM_MASTERS'(1) << winner;
          rr_ptr_d = (winner == PW'(NUM_MASTERS - 1)) ? '0 : winner + 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (!m_cyc) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (wd_fire) begin
          state_d = StAbort;
        end
      end
      StAbort: begin
        state_d = StIdle;
        grant_d = '0;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (TIMEOUT == 0 || !busy || term) begin
      wd_cnt_d = '0;
    end else if (m_stb && !wd_fire) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    wbs_adr_o = busy ? m_adr : '0;
    wbs_dat_o = busy ? m_dat : '0;
    wbs_sel_o = busy ? m_sel : '0;
    wbs_cti_o = busy ? m_cti : '0;
    wbs_bte_o = busy ? m_bte : '0;
    wbs_cyc_o = busy & m_cyc;
    wbs_stb_o = busy & m_stb;
    wbs_we_o  = busy & m_we;
    wbm_ack_o = (busy && wbs_ack_i) ? grant_q : '0;
    wbm_rty_o = (busy && wbs_rty_i) ? grant_q : '0;
    wbm_err_o = ((busy && wbs_err_i) || state_q == StAbort) ? grant_q : '0;
  end

  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_ddr2_port_arbiter.sv
// Directed bench for wb_ddr2_port_arbiter: one instance with a 16-cycle watchdog and one with
// the watchdog disabled, both driven by the same master/slave stimulus.
module tb_wb_ddr2_port_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic              wb_clk = 1'b0;
  logic              wb_rst;
  logic [N*AW-1:0]   wbm_adr_i;
  logic [N*DW-1:0]   wbm_dat_i;
  logic [N*DW/8-1:0] wbm_sel_i;
  logic [N*3-1:0]    wbm_cti_i;
  logic [N*2-1:0]    wbm_bte_i;
  logic [N-1:0]      wbm_cyc_i, wbm_stb_i, wbm_we_i;
  logic              wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic [DW-1:0]     wbs_dat_i;

  logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [DW-1:0]     wbm_dat_o, wbs_dat_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW/8-1:0]   wbs_sel_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic              wbs_cyc_o, wbs_stb_o, wbs_we_o;

  logic [N-1:0]      n_ack, n_err, n_rty, n_grant;
  logic [DW-1:0]     n_mdat, n_sdat;
  logic [AW-1:0]     n_adr;
  logic [DW/8-1:0]   n_sel;
  logic [2:0]        n_cti;
  logic [1:0]        n_bte;
  logic              n_cyc, n_stb, n_we;

  int checks = 0;
  int errors = 0;
  logic nowd_err_seen;

  always #5 wb_clk = ~wb_clk;

  wb_ddr2_port_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(16)) u_dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
    .wbm_dat_o(wbm_dat_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .wbs_dat_i(wbs_dat_i), .grant_o(grant_o)
  );

  wb_ddr2_port_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(0)) u_dut_nowd (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i), .wbm_we_i(wbm_we_i),
    .wbm_ack_o(n_ack), .wbm_err_o(n_err), .wbm_rty_o(n_rty),
    .wbm_dat_o(n_mdat),
    .wbs_adr_o(n_adr), .wbs_dat_o(n_sdat), .wbs_sel_o(n_sel),
    .wbs_cti_o(n_cti), .wbs_bte_o(n_bte),
    .wbs_cyc_o(n_cyc), .wbs_stb_o(n_stb), .wbs_we_o(n_we),
    .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
    .wbs_dat_i(wbs_dat_i), .grant_o(n_grant)
  );

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int i, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl,
                       input logic [2:0] ct);
    wbm_cyc_i[i]          = c;
    wbm_stb_i[i]          = s;
    wbm_we_i[i]           = w;
    wbm_adr_i[i*AW +: AW] = a;
    wbm_dat_i[i*DW +: DW] = d;
    wbm_sel_i[i*4 +: 4]   = sl;
    wbm_cti_i[i*3 +: 3]   = ct;
    wbm_bte_i[i*2 +: 2]   = 2'b00;
  endtask

  initial begin
    wb_rst    = 1'b1;
    wbm_adr_i = '0;
    wbm_dat_i = '0;
    wbm_sel_i = '0;
    wbm_cti_i = '0;
    wbm_bte_i = '0;
    wbm_cyc_i = '0;
    wbm_stb_i = '0;
    wbm_we_i  = '0;
    wbs_ack_i = 1'b0;
    wbs_err_i = 1'b0;
    wbs_rty_i = 1'b0;
    wbs_dat_i = '0;
    nowd_err_seen = 1'b0;
    tick();
    tick();
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", wbs_cyc_o, 0);
    chk("rst_ack", wbm_ack_o, 0);
    chk("rst_err", wbm_err_o, 0);
    wb_rst = 1'b0;

    // Routing: master 1 single write; rr_ptr starts at 0.
    set_m(1, 1, 1, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 3'b000);
    wbs_dat_i = 32'h1234_5678;
    #1;
    chk("arb_latency", grant_o, 0);
    chk("dat_bcast", wbm_dat_o, 32'h1234_5678);
    tick();
    chk("route_grant", grant_o, 4'b0010);
    chk("route_cyc", wbs_cyc_o, 1);
    chk("route_adr", wbs_adr_o, 32'h0000_1000);
    chk("route_dat", wbs_dat_o, 32'hDEAD_BEEF);
    chk("route_sel", wbs_sel_o, 4'b0011);
    chk("route_we", wbs_we_o, 1);
    wbs_ack_i = 1'b1;
    #1;
    chk("route_ack", wbm_ack_o, 4'b0010);
    tick();
    wbs_ack_i = 1'b0;
    set_m(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("route_ack_once", wbm_ack_o, 0);
    chk("route_cyc_drop", wbs_cyc_o, 0);
    tick();
    chk("route_release", grant_o, 0);

    // Burst hold: rr_ptr is 2, so master 2 beats master 0.
    set_m(0, 1, 1, 0, 32'h40, 0, 4'hF, 3'b000);
    set_m(2, 1, 1, 0, 32'h2000, 0, 4'hF, 3'b010);
    tick();
    chk("burst_grant", grant_o, 4'b0100);
    chk("burst_cti", wbs_cti_o, 3'b010);
    for (int k = 0; k < 8; k++) begin
      set_m(2, 1, 1, 0, 32'h2000 + 32'(4 * k), 0, 4'hF, (k == 7) ? 3'b111 : 3'b010);
      wbs_ack_i = 1'b1;
      #1;
      chk("burst_ack", wbm_ack_o, 4'b0100);
      chk("burst_adr", wbs_adr_o, 32'h2000 + 32'(4 * k));
      tick();
    end
    set_m(2, 0, 0, 0, 0, 0, 0, 0);
    wbs_ack_i = 1'b0;
    #1;
    chk("burst_hold", grant_o, 4'b0100);
    chk("burst_no_ack", wbm_ack_o, 0);
    tick();
    chk("burst_gap", grant_o, 0);
    tick();
    chk("burst_next", grant_o, 4'b0001);

    // Asynchronous reset while master 0 is being acked.
    wbs_ack_i = 1'b1;
    #1;
    chk("pre_rst_ack", wbm_ack_o, 4'b0001);
    #2;
    wb_rst = 1'b1;
    #1;
    chk("rst_async_grant", grant_o, 0);
    chk("rst_async_cyc", wbs_cyc_o, 0);
    chk("rst_async_ack", wbm_ack_o, 0);
    tick();
    wb_rst    = 1'b0;
    wbs_ack_i = 1'b0;

    // Round-robin: all four request; expect 0,1,2,3,0 with an idle cycle between owners.
    for (int i = 0; i < 4; i++) set_m(i, 1, 1, 0, 32'(32'h100 * i), 0, 4'hF, 3'b000);
    tick();
    for (int r = 0; r < 5; r++) begin
      int k;
      k = r % 4;
      chk("rr_grant", grant_o, 4'b0001 << k);
      wbs_ack_i = 1'b1;
      #1;
      chk("rr_ack", wbm_ack_o, 4'b0001 << k);
      tick();
      wbs_ack_i    = 1'b0;
      wbm_cyc_i[k] = 1'b0;
      wbm_stb_i[k] = 1'b0;
      tick();
      chk("rr_gap", grant_o, 0);
      if (r == 4) begin
        wbm_cyc_i = '0;
        wbm_stb_i = '0;
      end else begin
        wbm_cyc_i[k] = 1'b1;
        wbm_stb_i[k] = 1'b1;
      end
      tick();
    end

    // Retry to master 3 (rr_ptr is 1).
    set_m(3, 1, 1, 0, 32'h3000, 0, 4'hF, 3'b000);
    tick();
    chk("rty_grant", grant_o, 4'b1000);
    wbs_rty_i = 1'b1;
    #1;
    chk("rty_route", wbm_rty_o, 4'b1000);
    chk("rty_no_ack", wbm_ack_o, 0);
    chk("rty_no_err", wbm_err_o, 0);
    tick();
    wbs_rty_i = 1'b0;
    tick();
    chk("rty_hold", grant_o, 4'b1000);
    set_m(3, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("rty_release", grant_o, 0);

    // Watchdog: master 1 with a slave that never answers (rr_ptr is 0).
    set_m(1, 1, 1, 0, 32'h5000, 0, 4'hF, 3'b000);
    tick();
    chk("wd_grant", grant_o, 4'b0010);
    repeat (15) begin
      if (n_err != 0) nowd_err_seen = 1'b1;
      tick();
    end
    chk("wd_before_limit", wbm_err_o, 0);
    tick();
    chk("wd_err", wbm_err_o, 4'b0010);
    chk("wd_cyc_low", wbs_cyc_o, 0);
    chk("wd_stb_low", wbs_stb_o, 0);
    chk("nowd_err", n_err, 0);
    chk("nowd_cyc", n_cyc, 1);
    chk("nowd_err_seen", nowd_err_seen, 0);
    set_m(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wd_release", grant_o, 0);
    chk("wd_err_once", wbm_err_o, 0);

    // Ack arriving in the limit cycle beats the watchdog (rr_ptr is 2).
    set_m(2, 1, 1, 0, 32'h6000, 0, 4'hF, 3'b000);
    tick();
    chk("wdp_grant", grant_o, 4'b0100);
    repeat (15) tick();
    wbs_ack_i = 1'b1;
    #1;
    chk("wdp_ack", wbm_ack_o, 4'b0100);
    chk("wdp_err_same", wbm_err_o, 0);
    tick();
    wbs_ack_i = 1'b0;
    #1;
    chk("wdp_no_err", wbm_err_o, 0);
    chk("wdp_hold", grant_o, 4'b0100);
    set_m(2, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("wdp_release", grant_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
